// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational alu through an IDLE/EXEC FSM.
// Macro ALU_ARBITER_RR_EN selects round-robin tie breaking; default build is fixed priority (req0 wins).

module alu (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_aluc,
    output logic [31:0] o_out,
    output logic [3:0]  o_flags
);
    logic [32:0] w_add;
    logic [32:0] w_sub;
    logic        w_cout;
    logic        w_ovf;

    // cout on sub is the carry of a + ~b + 1, i.e. 1 when no borrow
    assign w_add = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;

    always_comb begin
        o_out  = 32'd0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (i_aluc)
            4'b0000: begin
                o_out  = w_add[31:0];
                w_cout = w_add[32];
                w_ovf  = (i_a[31] == i_b[31]) && (w_add[31] != i_a[31]);
            end
            4'b0001: begin
                o_out  = w_sub[31:0];
                w_cout = w_sub[32];
                w_ovf  = (i_a[31] != i_b[31]) && (w_sub[31] != i_a[31]);
            end
            4'b0010: o_out = i_a & i_b;
            4'b0011: o_out = i_a | i_b;
            4'b0100: o_out = i_a ^ i_b;
            4'b0101: o_out = ~(i_a | i_b);
            4'b0110: o_out = {31'd0, $signed(i_a) < $signed(i_b)};
            4'b0111: o_out = {31'd0, i_a < i_b};
            4'b1000: o_out = i_a << i_b[4:0];
            4'b1001: o_out = $signed(i_a) >>> i_b[4:0];
            4'b1010: o_out = i_a >> i_b[4:0];
            4'b1011: o_out = {i_b[15:0], 16'd0};
            default: o_out = 32'd0;
        endcase
    end

    // {zero, cout, overflow, sign}
    assign o_flags = {o_out == 32'd0, w_cout, w_ovf, o_out[31]};
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    input  logic [3:0]  req0_aluc,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,
    output logic [3:0]  rsp0_flags,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    input  logic [3:0]  req1_aluc,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out,
    output logic [3:0]  rsp1_flags
);
`ifdef ALU_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic {IDLE, EXEC} state_t;

    state_t      r_state;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [3:0]  r_aluc;
    logic        r_gid;
    logic        r_last_grant;
    logic        r_rsp0_valid;
    logic [31:0] r_rsp0_out;
    logic [3:0]  r_rsp0_flags;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp1_out;
    logic [3:0]  r_rsp1_flags;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_accept;
    logic        w_gnt_id;
    logic [31:0] w_alu_out;
    logic [3:0]  w_alu_flags;

    // A response draining this cycle still blocks its requester until the next cycle
    assign w_elig0  = (r_state == IDLE) && req0_valid && !r_rsp0_valid;
    assign w_elig1  = (r_state == IDLE) && req1_valid && !r_rsp1_valid;
    assign w_accept = w_elig0 || w_elig1;
    assign w_gnt_id = (w_elig0 && w_elig1) ? (RR_EN ? ~r_last_grant : 1'b0) : w_elig1;

    assign req0_ready = w_accept && !w_gnt_id;
    assign req1_ready = w_accept &&  w_gnt_id;

    alu u_alu (
        .i_a     (r_src1),
        .i_b     (r_src2),
        .i_aluc  (r_aluc),
        .o_out   (w_alu_out),
        .o_flags (w_alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_src1       <= 32'd0;
            r_src2       <= 32'd0;
            r_aluc       <= 4'd0;
            r_gid        <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp0_out   <= 32'd0;
            r_rsp0_flags <= 4'd0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_out   <= 32'd0;
            r_rsp1_flags <= 4'd0;
        end else begin
            if (r_rsp0_valid && rsp0_ready) r_rsp0_valid <= 1'b0;
            if (r_rsp1_valid && rsp1_ready) r_rsp1_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_src1       <= w_gnt_id ? req1_src1 : req0_src1;
                        r_src2       <= w_gnt_id ? req1_src2 : req0_src2;
                        r_aluc       <= w_gnt_id ? req1_aluc : req0_aluc;
                        r_gid        <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    // The granted requester's response slot is always empty here
                    if (!r_gid) begin
                        r_rsp0_out   <= w_alu_out;
                        r_rsp0_flags <= w_alu_flags;
                        r_rsp0_valid <= 1'b1;
                    end else begin
                        r_rsp1_out   <= w_alu_out;
                        r_rsp1_flags <= w_alu_flags;
                        r_rsp1_valid <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_out   = r_rsp0_out;
    assign rsp0_flags = r_rsp0_flags;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_out   = r_rsp1_out;
    assign rsp1_flags = r_rsp1_flags;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a negedge monitor queues model results at request
// handshakes and compares them at response handshakes; scenario tasks check timing inline.
`timescale 1ns/1ps
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [31:0] req0_src1, req0_src2, rsp0_out;
    logic [3:0]  req0_aluc, rsp0_flags;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req1_src1, req1_src2, rsp1_out;
    logic [3:0]  req1_aluc, rsp1_flags;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [35:0] q0[$];
    logic [35:0] q1[$];
    int          gq[$];
    int          gcyc[$];

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_aluc(req0_aluc), .rsp0_valid(rsp0_valid),
        .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out), .rsp0_flags(rsp0_flags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_aluc(req1_aluc), .rsp1_valid(rsp1_valid),
        .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out), .rsp1_flags(rsp1_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {out, zero, cout, overflow, sign}; sub cout means "no borrow"
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [31:0] r;
        logic        c, v;
        longint      sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: begin
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s > MAXI) || (s < MINI);
            end
            4'b0001: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > MAXI) || (s < MINI);
            end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b1001: r = $signed(a) >>> b[4:0];
            default: r = 32'd0;
        endcase
        return {r, r == 32'd0, c, v, r[31]};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                q0.push_back(alu_model(req0_src1, req0_src2, req0_aluc));
                gq.push_back(0); gcyc.push_back(cyc);
            end
            if (req1_valid && req1_ready) begin
                q1.push_back(alu_model(req1_src1, req1_src2, req1_aluc));
                gq.push_back(1); gcyc.push_back(cyc);
            end
            if (req0_ready || req1_ready) begin
                n_total++;
                if (req0_ready && req1_ready)
                    $display("FAIL grant_onehot: got ready=%b%b, expected one-hot", req1_ready, req0_ready);
                else n_pass++;
            end
            if (rsp0_valid && rsp0_ready) begin
                n_total++;
                if (q0.size() == 0)
                    $display("FAIL rsp0_unexpected: got %h/%b, expected no response", rsp0_out, rsp0_flags);
                else begin
                    logic [35:0] e0;
                    e0 = q0.pop_front();
                    if ({rsp0_out, rsp0_flags} !== e0)
                        $display("FAIL rsp0_data: got %h/%b, expected %h/%b", rsp0_out, rsp0_flags, e0[35:4], e0[3:0]);
                    else n_pass++;
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                n_total++;
                if (q1.size() == 0)
                    $display("FAIL rsp1_unexpected: got %h/%b, expected no response", rsp1_out, rsp1_flags);
                else begin
                    logic [35:0] e1;
                    e1 = q1.pop_front();
                    if ({rsp1_out, rsp1_flags} !== e1)
                        $display("FAIL rsp1_data: got %h/%b, expected %h/%b", rsp1_out, rsp1_flags, e1[35:4], e1[3:0]);
                    else n_pass++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req0_valid = v; req0_src1 = a; req0_src2 = b; req0_aluc = op;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req1_valid = v; req1_src1 = a; req1_src2 = b; req1_aluc = op;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        q0.delete(); q1.delete();
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive0(1'b0, 32'd0, 32'd0, 4'd0); drive1(1'b0, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #2;
        n_total++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00)
            $display("FAIL reset_valid: got %b, expected 00", {rsp0_valid, rsp1_valid});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({rsp0_out, rsp0_flags, rsp1_out, rsp1_flags} !== 72'd0)
            $display("FAIL reset_data: got %h, expected 0", {rsp0_out, rsp0_flags, rsp1_out, rsp1_flags});
        else n_pass++;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_single_add;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        drive0(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0000);
        @(negedge clk);
        n_total++;
        if ({req1_ready, req0_ready} !== 2'b01)
            $display("FAIL add_accept: got ready=%b, expected 01", {req1_ready, req0_ready});
        else n_pass++;
        tick;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        drive1(1'b1, 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0010);
        @(negedge clk);
        n_total++;
        if ({rsp0_valid, req1_ready, req0_ready} !== 3'b000)
            $display("FAIL add_exec: got valid/ready=%b, expected 000", {rsp0_valid, req1_ready, req0_ready});
        else n_pass++;
        tick;
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        n_total++;
        if ({rsp0_valid, rsp0_out, rsp0_flags} !== {1'b1, 32'h8000_0000, 4'b0011})
            $display("FAIL add_result: got %b/%h/%b, expected 1/80000000/0011", rsp0_valid, rsp0_out, rsp0_flags);
        else n_pass++;
        tick;
        rsp0_ready = 1'b1;
        tick;
        @(negedge clk);
        n_total++;
        if (rsp0_valid !== 1'b0)
            $display("FAIL add_release: got valid=%b, expected 0", rsp0_valid);
        else n_pass++;
    endtask

    task automatic test_tie;
        apply_reset;
        gq.delete(); gcyc.delete();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive0(1'b1, 32'h0000_1234, 32'd1, 4'b0000);
        drive1(1'b1, 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0010);
        for (int i = 0; i < 8; i++) tick;
        drive0(1'b0, 32'd0, 32'd0, 4'd0); drive1(1'b0, 32'd0, 32'd0, 4'd0);
        n_total++;
        if (gq.size() != 4)
            $display("FAIL tie_count: got %0d grants, expected 4", gq.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            n_total++;
            if (gq[i] != (i % 2))
                $display("FAIL tie_order: grant %0d got %0d, expected %0d", i, gq[i], i % 2);
            else n_pass++;
        end
        for (int i = 1; i < gcyc.size(); i++) begin
            n_total++;
            if (gcyc[i] - gcyc[i-1] != 2)
                $display("FAIL tie_spacing: got %0d cycles, expected 2", gcyc[i] - gcyc[i-1]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) tick;
    endtask

    task automatic test_policy;
        logic [1:0] exp_gnt;
        apply_reset;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive0(1'b1, 32'd3, 32'd4, 4'b0000);
        tick;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        tick; tick;
`ifdef ALU_ARBITER_RR_EN
        exp_gnt = 2'b10;
`else
        exp_gnt = 2'b01;
`endif
        drive0(1'b1, 32'd9, 32'd2, 4'b0001);
        drive1(1'b1, 32'd7, 32'd8, 4'b0011);
        @(negedge clk);
        n_total++;
        if ({req1_ready, req0_ready} !== exp_gnt)
            $display("FAIL policy_tie: got ready=%b, expected %b", {req1_ready, req0_ready}, exp_gnt);
        else n_pass++;
        tick;
        drive0(1'b0, 32'd0, 32'd0, 4'd0); drive1(1'b0, 32'd0, 32'd0, 4'd0);
        for (int i = 0; i < 4; i++) tick;
    endtask

    task automatic test_backpressure;
        logic seen;
        seen = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        drive0(1'b1, 32'd5, 32'd5, 4'b0001);
        @(negedge clk);
        n_total++;
        if (req0_ready !== 1'b1)
            $display("FAIL bp_accept: got ready=%b, expected 1", req0_ready);
        else n_pass++;
        tick;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        tick;
        drive0(1'b1, 32'd1, 32'd1, 4'b0000);
        drive1(1'b1, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if ({rsp0_valid, rsp0_out, rsp0_flags[3], req0_ready} !== {1'b1, 32'd0, 1'b1, 1'b0})
                $display("FAIL bp_hold: cycle %0d got %b/%h/%b/%b, expected 1/00000000/1/0",
                         i, rsp0_valid, rsp0_out, rsp0_flags[3], req0_ready);
            else n_pass++;
            if (rsp1_valid && !seen) begin
                seen = 1'b1;
                n_total++;
                if (rsp1_out !== 32'h0F0F_0F0F)
                    $display("FAIL bp_xor: got %h, expected 0f0f0f0f", rsp1_out);
                else n_pass++;
            end
            tick;
            if (i == 0) drive1(1'b0, 32'd0, 32'd0, 4'd0);
        end
        n_total++;
        if (!seen) $display("FAIL bp_rsp1_seen: got no rsp1, expected one");
        else n_pass++;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b1;
        tick; tick;
    endtask

    task automatic test_same_cycle_release;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        drive0(1'b1, 32'h00FF_0000, 32'h0000_00FF, 4'b0011);
        tick;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        tick;
        rsp0_ready = 1'b1;
        drive0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0000);
        @(negedge clk);
        n_total++;
        if ({req0_ready, rsp0_valid, rsp0_out} !== {1'b0, 1'b1, 32'h00FF_00FF})
            $display("FAIL scr_same: got %b/%b/%h, expected 0/1/00ff00ff", req0_ready, rsp0_valid, rsp0_out);
        else n_pass++;
        tick;
        @(negedge clk);
        n_total++;
        if (req0_ready !== 1'b1)
            $display("FAIL scr_next: got ready=%b, expected 1", req0_ready);
        else n_pass++;
        tick;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        tick;
        @(negedge clk);
        n_total++;
        if ({rsp0_valid, rsp0_out, rsp0_flags} !== {1'b1, 32'd0, 4'b1100})
            $display("FAIL scr_result: got %b/%h/%b, expected 1/00000000/1100", rsp0_valid, rsp0_out, rsp0_flags);
        else n_pass++;
        tick; tick;
    endtask

    task automatic test_reset_mid_exec;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive1(1'b1, 32'h8000_0000, 32'd4, 4'b1001);
        @(negedge clk);
        n_total++;
        if (req1_ready !== 1'b1)
            $display("FAIL rme_accept: got ready=%b, expected 1", req1_ready);
        else n_pass++;
        tick;
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        #1 rst_n = 1'b0;
        q1.delete();
        #1;
        n_total++;
        if (rsp1_valid !== 1'b0)
            $display("FAIL rme_async: got valid=%b, expected 0", rsp1_valid);
        else n_pass++;
        tick; tick;
        rst_n = 1'b1;
        drive1(1'b1, 32'd10, 32'd3, 4'b0001);
        @(negedge clk);
        n_total++;
        if ({rsp1_valid, req1_ready} !== 2'b01)
            $display("FAIL rme_first_idle: got valid/ready=%b, expected 01", {rsp1_valid, req1_ready});
        else n_pass++;
        tick;
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        n_total++;
        if (rsp1_valid !== 1'b0)
            $display("FAIL rme_no_ghost: got valid=%b, expected 0", rsp1_valid);
        else n_pass++;
        tick;
        @(negedge clk);
        n_total++;
        if ({rsp1_valid, rsp1_out} !== {1'b1, 32'd7})
            $display("FAIL rme_new: got %b/%h, expected 1/00000007", rsp1_valid, rsp1_out);
        else n_pass++;
        tick; tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_add;
        test_tie;
        test_policy;
        test_backpressure;
        test_same_cycle_release;
        test_reset_mid_exec;
        n_total++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL provide the following ports for requester i (i = 0, 1):
- reqi_valid  input  1  operation request.
- reqi_ready  output  1  request accepted this cycle.
- reqi_src1  input  32  operand 1.
- reqi_src2  input  32  operand 2.
- reqi_aluc  input  4  ALU opcode, passed unmodified to the shared alu.
- rspi_valid  output  1  result held.
- rspi_ready  input  1  result consumed.
- rspi_out  output  32  ALU result.
- rspi_flags  output  4  {zero, cout, overflow, sign} from the ALU.
REQ-003 The block SHALL instantiate exactly one alu and share it between both requesters.

Function
REQ-004 The FSM SHALL have two states: IDLE and EXEC.
REQ-005 Requester i SHALL be eligible only when state is IDLE, reqi_valid = 1 and rspi_valid = 0; a response handshake in the same cycle does not make it eligible.
REQ-006 In IDLE, the block SHALL assert reqi_ready combinationally for exactly one eligible requester (the grant) and for no other requester.
REQ-007 On a request handshake, the block SHALL latch src1, src2, aluc and the grant id into internal operand registers and SHALL move IDLE->EXEC.
REQ-008 In EXEC, the ALU SHALL be driven only from the operand registers, and every reqi_ready SHALL be 0.
REQ-009 At the clock edge that ends EXEC, the block SHALL:
- load the ALU out and flags into rsp_out/rsp_flags of the granted requester;
- set that requester's rsp_valid to 1;
- move to IDLE.
REQ-010 Latency SHALL be: request handshake at edge k -> rspi_valid = 1 after edge k+1. Throughput SHALL be at most one operation per 2 cycles.
REQ-011 rspi_valid, rspi_out and rspi_flags SHALL hold stable until an edge where rspi_valid and rspi_ready are both 1, which clears rspi_valid; out and flags are then don't-care.
REQ-012 A pending response on one requester SHALL NOT block acceptance of the other requester.
REQ-013 Both response registers SHALL be independent, so both may hold valid results at the same time.
REQ-014 A last_grant register SHALL be updated to the grant id on every request handshake.
REQ-015 A requester that drops reqi_valid while not granted SHALL have no side effects.

Reset
REQ-016 Asserting rst_n low SHALL immediately set: state = IDLE, rsp0_valid = rsp1_valid = 0, rsp out and flags = 0, operand registers = 0, last_grant = 1.
REQ-017 Reset asserted during EXEC SHALL discard the in-flight operation, and no response SHALL be produced after reset is released.
REQ-018 On the first IDLE cycle after rst_n deasserts, the block SHALL accept a request.

Configuration
REQ-019 The arbitration policy SHALL be controlled by the macro ALU_ARBITER_RR_EN.
REQ-020 With ALU_ARBITER_RR_EN defined, arbitration SHALL be round-robin: when both requesters are eligible, the grant goes to the requester that is not last_grant. Reset value last_grant = 1, so requester 0 wins the first tie.
REQ-021 Without ALU_ARBITER_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning a tie; last_grant is still maintained but unused.
REQ-022 With a single eligible requester, the grant SHALL go to that requester regardless of policy.

Verification
REQ-023 Single add: req0 {src1 = 32'h7FFFFFFF, src2 = 1, aluc = 0000} accepted at edge k -> rsp0_valid after edge k+1, rsp0_out = 32'h80000000, rsp0_flags = {0,0,1,1}.
REQ-024 Tie, RR build: req0 and req1 held valid continuously, rsp_ready = 1 -> grants alternate 0,1,0,1 with accepts every 2 cycles. Fixed build -> req0 granted every time; req1 granted only on cycles when req0 is ineligible.
REQ-025 Backpressure: rsp0_ready = 0, req0 sub {5,5,0001} completes -> rsp0_out = 0, zero = 1, held stable for 10 cycles; req0 ready stays 0; req1 xor {32'hF0F0F0F0, 32'hFFFFFFFF, 0100} still completes with rsp1_out = 32'h0F0F0F0F.
REQ-026 Reset mid-EXEC: rst_n pulled low in EXEC of req1 sra {32'h80000000, 4, 1001} -> rsp1_valid stays 0 after release; next req1 accepted in the first IDLE cycle.
REQ-027 Same-cycle release: rsp0 handshake and req0_valid in the same cycle -> req0_ready = 0 that cycle and 1 in the next cycle; the result is correct.
